zap_icache_dm: RTL and testbench
================================

Name: zap_icache_dm

Overview:
- Direct-mapped, read-only instruction cache feeding the ZAP core fetch port (o_pc in, instruction/valid/abort out).
- Upstream of zap_top; replaces the behavioural code-memory model.
- Misses are filled word-by-word from a backing memory over a req/ack handshake.
- Reports fetch faults as a one-cycle abort.

Parameters:
- LINES, 16, number of cache lines; power of 2, ≥2.
- WORDS, 4, 32-bit words per line; power of 2, ≥2.

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_reset_n  in  1  asynchronous active-low reset.
- i_address  in  32  fetch byte address; bits [1:0] ignored.
- i_rd_en  in  1  fetch request.
- i_flush  in  1  invalidate all lines.
- o_data  out  32  instruction word.
- o_hit  out  1  o_data valid this cycle.
- o_miss  out  1  fetch stalled.
- o_abort  out  1  fetch fault (one-cycle pulse).
- o_mem_req  out  1  backing memory word request.
- o_mem_addr  out  32  word-aligned request address.
- i_mem_ack  in  1  word returned.
- i_mem_data  in  32  returned word.
- i_mem_err  in  1  bus error, qualified by i_mem_ack.

Behaviour:
- Address split: offset = addr[2+log2(WORDS)-1:2]; index = next log2(LINES) bits; tag = remaining upper bits.
- Storage: data array, tag array, valid bit per line. Only the valid bits are reset.
- Reset (async, i_reset_n=0):
  - state=IDLE; all valid=0.
  - o_hit=0, o_miss=0, o_abort=0, o_mem_req=0, o_mem_addr=0, o_data=0.
  - Reset during FILL abandons the fill immediately; the line stays invalid.
- Lookup is combinational from registered arrays: hit = i_rd_en & valid[index] & tag match & state==IDLE.
- IDLE:
  - Hit -> o_hit=1, o_data=word, same cycle (0-cycle latency).
  - i_rd_en & miss -> latch line base address, word counter=0, go FILL; o_miss=1 that cycle.
  - i_rd_en=0 -> o_hit=o_miss=0; o_data holds its last value.
- FILL:
  - o_miss=1, o_hit=0.
  - o_mem_req=1, o_mem_addr = line base + 4·counter.
  - req stays high until i_mem_ack; req does not drop between words (next address is presented the cycle after ack).
  - On ack without err: write the word and increment counter.
  - After the last word (counter==WORDS-1): write tag, set valid, drop req, go IDLE. The first hit is possible the next cycle.
  - Ack with i_mem_err: drop req, line stays invalid, go ABORT.
  - A change of i_address during FILL does not affect the fill in progress.
- ABORT: o_abort=1, o_hit=0, o_miss=0 for exactly one cycle, then IDLE. A refetch of the same address misses again and re-fills.
- Flush:
  - In IDLE/ABORT: all valid=0 at the next edge; a hit in the flush cycle still returns data.
  - During FILL: sets flush_pend. The fill completes its handshake, but valid is not set. All valid=0 at once; flush_pend clears on return to IDLE.
- i_mem_ack while o_mem_req=0 is ignored.
- o_miss and o_abort are never asserted together; o_hit and o_miss are never asserted together.

Optional Feature:
- ZAP_ICACHE_STATS_EN defined: adds outputs o_hit_cnt[31:0] and o_miss_cnt[31:0].
  - o_hit_cnt increments once per IDLE hit cycle.
  - o_miss_cnt increments once per IDLE->FILL transition.
  - Both reset to 0 and wrap modulo 2^32; i_flush does not clear them.
- Undefined: no counter logic and no counter ports.

Test Plan:
- Cold fetch 0x100, i_rd_en=1, memory ack every 2nd cycle -> o_miss=1; req addresses 0x100, 0x104, 0x108, 0x10C; the cycle after the final ack o_hit=1 and o_data = memory[0x100].
- Fetch 0x104..0x10C after fill -> o_hit=1 each cycle, no o_mem_req; then 0x500 (same index, different tag) -> miss, refill, 0x100 misses afterwards.
- Error on 3rd word of fill at 0x200 -> req drops, o_abort=1 for exactly 1 cycle, refetch 0x200 -> new miss starting at 0x200.
- i_flush during FILL of 0x300 -> all 4 acks consumed, then 0x300 misses again; i_flush in IDLE after line filled -> next fetch misses.
- Assert i_reset_n=0 mid-FILL -> o_mem_req=0 and o_miss=0 immediately (async); after release, the fetch misses and re-fills from word 0.
- With ZAP_ICACHE_STATS_EN: 1 cold miss + 7 hits -> o_miss_cnt=1, o_hit_cnt=7; preload 0xFFFFFFFF via force -> wraps to 0.

Source files
------------

// File: rtl/zap_icache_dm_if.sv
// Fetch-port and backing-memory signal bundle for zap_icache_dm.
// The cache sits on the slave modport; the core/memory side uses master.
interface zap_icache_dm_if;
  logic [31:0] i_address;
  logic        i_rd_en;
  logic        i_flush;
  logic [31:0] o_data;
  logic        o_hit;
  logic        o_miss;
  logic        o_abort;
  logic        o_mem_req;
  logic [31:0] o_mem_addr;
  logic        i_mem_ack;
  logic [31:0] i_mem_data;
  logic        i_mem_err;

  modport slave (
    input  i_address, i_rd_en, i_flush, i_mem_ack, i_mem_data, i_mem_err,
    output o_data, o_hit, o_miss, o_abort, o_mem_req, o_mem_addr
  );

  modport master (
    output i_address, i_rd_en, i_flush, i_mem_ack, i_mem_data, i_mem_err,
    input  o_data, o_hit, o_miss, o_abort, o_mem_req, o_mem_addr
  );
endinterface

// File: rtl/zap_icache_dm.sv
// Direct-mapped read-only instruction cache; misses fill a whole line word-by-word.
// Define ZAP_ICACHE_STATS_EN to add o_hit_cnt/o_miss_cnt counters.
module zap_icache_dm #(
  parameter int unsigned LINES = 16,
  parameter int unsigned WORDS = 4
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
`ifdef ZAP_ICACHE_STATS_EN
  output logic [31:0] o_hit_cnt,
  output logic [31:0] o_miss_cnt,
`endif
  zap_icache_dm_if.slave bus
);
  localparam int unsigned OffW  = $clog2(WORDS);
  localparam int unsigned IdxW  = $clog2(LINES);
  localparam int unsigned TagW  = 30 - OffW - IdxW;
  localparam int unsigned BaseW = 30 - OffW;
  localparam logic [OffW-1:0] LastWord = {OffW{1'b1}};

  typedef enum logic [1:0] {StIdle, StFill, StAbort} state_e;

  state_e           state_q;
  logic [LINES-1:0] valid_q;
  logic [TagW-1:0]  tag_mem  [LINES];
  logic [31:0]      data_mem [LINES*WORDS];
  logic [BaseW-1:0] base_q;
  logic [OffW-1:0]  cnt_q;
  logic             flush_pend_q;
  logic [31:0]      data_q;

  logic [TagW-1:0]  req_tag;
  logic [IdxW-1:0]  req_idx;
  logic [IdxW-1:0]  fill_idx;
  logic [OffW-1:0]  req_off;
  logic [31:0]      hit_word;
  logic             lookup_hit;
  logic             start_fill;
  logic             fill_ack;
  logic             fill_done;
  logic             unused_addr;

  assign req_tag     = bus.i_address[31 -: TagW];
  assign req_idx     = bus.i_address[2+OffW +: IdxW];
  assign req_off     = bus.i_address[2 +: OffW];
  assign unused_addr = ^bus.i_address[1:0];
  assign fill_idx    = base_q[IdxW-1:0];
  assign hit_word    = data_mem[{req_idx, req_off}];

  assign lookup_hit = bus.i_rd_en && (state_q == StIdle) && valid_q[req_idx] &&
                      (tag_mem[req_idx] == req_tag);
  assign start_fill = bus.i_rd_en && (state_q == StIdle) && !lookup_hit;
  assign fill_ack   = (state_q == StFill) && bus.i_mem_ack;
  assign fill_done  = fill_ack && !bus.i_mem_err && (cnt_q == LastWord);

  // o_miss is gated by reset so a held fetch request cannot show a stall while in reset.
  assign bus.o_hit      = lookup_hit;
  assign bus.o_miss     = i_reset_n && (start_fill || (state_q == StFill));
  assign bus.o_abort    = (state_q == StAbort);
  assign bus.o_mem_req  = (state_q == StFill);
  assign bus.o_mem_addr = {base_q, cnt_q, 2'b00};
  assign bus.o_data     = lookup_hit ? hit_word : data_q;

  // Arrays carry no reset; only valid_q qualifies their contents.
  always_ff @(posedge i_clk) begin
    if (fill_ack && !bus.i_mem_err) begin
      data_mem[{fill_idx, cnt_q}] <= bus.i_mem_data;
    end
    if (fill_done) begin
      tag_mem[fill_idx] <= base_q[BaseW-1 -: TagW];
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q      <= StIdle;
      valid_q      <= '0;
      base_q       <= '0;
      cnt_q        <= '0;
      flush_pend_q <= 1'b0;
      data_q       <= '0;
    end else begin
      if (lookup_hit) begin
        data_q <= hit_word;
      end
      if (bus.i_flush) begin
        valid_q <= '0;
      end
      case (state_q)
        StIdle: begin
          if (start_fill) begin
            base_q       <= bus.i_address[31:2+OffW];
            cnt_q        <= '0;
            flush_pend_q <= 1'b0;
            state_q      <= StFill;
          end
        end
        StFill: begin
          if (bus.i_flush) begin
            flush_pend_q <= 1'b1;
          end
          if (fill_ack) begin
            if (bus.i_mem_err) begin
              flush_pend_q <= 1'b0;
              state_q      <= StAbort;
            end else if (cnt_q == LastWord) begin
              // A flush seen at any point of the fill keeps the new line invalid.
              if (!flush_pend_q && !bus.i_flush) begin
                valid_q[fill_idx] <= 1'b1;
              end
              flush_pend_q <= 1'b0;
              state_q      <= StIdle;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        StAbort: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

`ifdef ZAP_ICACHE_STATS_EN
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (lookup_hit) begin
        hit_cnt_q <= hit_cnt_q + 32'd1;
      end
      if (start_fill) begin
        miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign o_hit_cnt  = hit_cnt_q;
  assign o_miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_zap_icache_dm.sv
// Self-checking bench for zap_icache_dm: memory responder plus request-address scoreboard.
// Counter checks are compiled only when ZAP_ICACHE_STATS_EN is defined.
module tb_zap_icache_dm;
  localparam int ModeHit   = 0;
  localparam int ModeAbort = 1;
  localparam int ModeAcks  = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned cyc = 0;
  int unsigned ack_cyc = 0;
  int          ack_gap = 2;
  int          err_at = -1;
  int          gap_cnt = 0;
  int          word_cnt = 0;
  logic [31:0] exp_addr_q[$];
  logic [31:0] obs_addr_q[$];

`ifdef ZAP_ICACHE_STATS_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  zap_icache_dm_if bus ();

  zap_icache_dm #(
    .LINES(16),
    .WORDS(4)
  ) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
`ifdef ZAP_ICACHE_STATS_EN
    .o_hit_cnt (hit_cnt),
    .o_miss_cnt(miss_cnt),
`endif
    .bus       (bus)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h3C00_0000;
  endfunction

  task automatic push_line(input logic [31:0] base);
    for (int i = 0; i < 4; i++) exp_addr_q.push_back(base + 32'(4 * i));
  endtask

  // Advance to the next falling edge and play the backing memory for that cycle.
  task automatic step();
    @(negedge clk);
    if (bus.o_mem_req) begin
      if (gap_cnt == ack_gap - 1) begin
        gap_cnt        = 0;
        bus.i_mem_ack  = 1'b1;
        bus.i_mem_data = mem_word(bus.o_mem_addr);
        bus.i_mem_err  = (word_cnt == err_at);
        obs_addr_q.push_back(bus.o_mem_addr);
        word_cnt++;
        ack_cyc = cyc;
      end else begin
        gap_cnt++;
        bus.i_mem_ack = 1'b0;
        bus.i_mem_err = 1'b0;
      end
    end else begin
      bus.i_mem_ack = 1'b0;
      bus.i_mem_err = 1'b0;
      gap_cnt       = 0;
      word_cnt      = 0;
    end
  endtask

  task automatic wait_for(input int mode, input int target, output bit got);
    got = 1'b0;
    for (int i = 0; i < 80; i++) begin
      step();
      #1;
      if ((mode == ModeHit && bus.o_hit) || (mode == ModeAbort && bus.o_abort) ||
          (mode == ModeAcks && obs_addr_q.size() >= target)) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.i_address = 32'h100;
    bus.i_rd_en   = 1'b1;
    bus.i_flush   = 1'b0;
    bus.i_mem_ack = 1'b0;
    bus.i_mem_data = '0;
    bus.i_mem_err = 1'b0;
    step();
    step();
    #1;
    vectors++;
    if ({bus.o_hit, bus.o_miss, bus.o_abort, bus.o_mem_req} !== 4'b0) begin
      miscompares++;
      $display("FAIL reset_flags: got %b want 0000",
               {bus.o_hit, bus.o_miss, bus.o_abort, bus.o_mem_req});
    end
    vectors++;
    if (bus.o_mem_addr !== 32'h0 || bus.o_data !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_buses: got addr=%h data=%h want 0/0", bus.o_mem_addr, bus.o_data);
    end
    step();
    bus.i_rd_en = 1'b0;
    rst_n       = 1'b1;
    #1;
  endtask

  task automatic test_cold_fill();
    bit got;
    logic [31:0] e, o;
    ack_gap = 2;
    step();
    bus.i_address = 32'h100;
    bus.i_rd_en   = 1'b1;
    push_line(32'h100);
    #1;
    vectors++;
    if (bus.o_miss !== 1'b1 || bus.o_hit !== 1'b0) begin
      miscompares++;
      $display("FAIL cold_first_miss: got miss=%b hit=%b want 1/0", bus.o_miss, bus.o_hit);
    end
    wait_for(ModeHit, 0, got);
    vectors++;
    if (!got) begin
      miscompares++;
      $display("FAIL cold_hit_timeout: got none want hit");
    end
    vectors++;
    if (cyc !== ack_cyc + 1) begin
      miscompares++;
      $display("FAIL cold_hit_latency: got cycle %0d want %0d", cyc, ack_cyc + 1);
    end
    vectors++;
    if (bus.o_data !== mem_word(32'h100)) begin
      miscompares++;
      $display("FAIL cold_data: got %h want %h", bus.o_data, mem_word(32'h100));
    end
    while (exp_addr_q.size() > 0) begin
      e = exp_addr_q.pop_front();
      o = (obs_addr_q.size() > 0) ? obs_addr_q.pop_front() : 32'hDEAD_DEAD;
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL cold_req_addr: got %h want %h", o, e);
      end
    end
  endtask

  task automatic test_hits_and_conflict();
    bit got;
    logic [31:0] e, o;
    logic [31:0] addrs [4];
    addrs = '{32'h104, 32'h108, 32'h10C, 32'h100};
    for (int i = 0; i < 4; i++) begin
      step();
      bus.i_address = addrs[i];
      #1;
      vectors++;
      if (bus.o_hit !== 1'b1 || bus.o_mem_req !== 1'b0 || bus.o_data !== mem_word(addrs[i])) begin
        miscompares++;
        $display("FAIL hit_%h: got hit=%b req=%b data=%h want 1/0/%h", addrs[i], bus.o_hit,
                 bus.o_mem_req, bus.o_data, mem_word(addrs[i]));
      end
    end
    step();
    bus.i_rd_en = 1'b0;
    #1;
    vectors++;
    if (bus.o_hit !== 1'b0 || bus.o_miss !== 1'b0 || bus.o_data !== mem_word(32'h100)) begin
      miscompares++;
      $display("FAIL idle_hold: got hit=%b miss=%b data=%h want 0/0/%h", bus.o_hit,
               bus.o_miss, bus.o_data, mem_word(32'h100));
    end
    step();
    bus.i_address = 32'h500;
    bus.i_rd_en   = 1'b1;
    push_line(32'h500);
    #1;
    vectors++;
    if (bus.o_miss !== 1'b1 || bus.o_hit !== 1'b0) begin
      miscompares++;
      $display("FAIL conflict_miss: got miss=%b hit=%b want 1/0", bus.o_miss, bus.o_hit);
    end
    wait_for(ModeHit, 0, got);
    vectors++;
    if (!got || bus.o_data !== mem_word(32'h500)) begin
      miscompares++;
      $display("FAIL conflict_data: got %h want %h", bus.o_data, mem_word(32'h500));
    end
    step();
    bus.i_address = 32'h100;
    push_line(32'h100);
    #1;
    vectors++;
    if (bus.o_miss !== 1'b1 || bus.o_hit !== 1'b0) begin
      miscompares++;
      $display("FAIL evicted_miss: got miss=%b hit=%b want 1/0", bus.o_miss, bus.o_hit);
    end
    wait_for(ModeHit, 0, got);
    vectors++;
    if (!got) begin
      miscompares++;
      $display("FAIL evicted_refill_timeout: got none want hit");
    end
    while (exp_addr_q.size() > 0) begin
      e = exp_addr_q.pop_front();
      o = (obs_addr_q.size() > 0) ? obs_addr_q.pop_front() : 32'hDEAD_DEAD;
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL conflict_req_addr: got %h want %h", o, e);
      end
    end
  endtask

  task automatic test_abort();
    bit got;
    logic [31:0] e, o;
    ack_gap = 1;
    err_at  = 2;
    step();
    bus.i_address = 32'h200;
    bus.i_rd_en   = 1'b1;
    exp_addr_q.push_back(32'h200);
    exp_addr_q.push_back(32'h204);
    exp_addr_q.push_back(32'h208);
    #1;
    wait_for(ModeAbort, 0, got);
    vectors++;
    if (!got || bus.o_miss !== 1'b0 || bus.o_hit !== 1'b0 || bus.o_mem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_cycle: got abort=%b miss=%b hit=%b req=%b want 1/0/0/0", got,
               bus.o_miss, bus.o_hit, bus.o_mem_req);
    end
    err_at = -1;
    step();
    push_line(32'h200);
    #1;
    vectors++;
    if (bus.o_abort !== 1'b0 || bus.o_miss !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_one_cycle: got abort=%b miss=%b want 0/1", bus.o_abort, bus.o_miss);
    end
    wait_for(ModeHit, 0, got);
    vectors++;
    if (!got || bus.o_data !== mem_word(32'h200)) begin
      miscompares++;
      $display("FAIL abort_refill_data: got %h want %h", bus.o_data, mem_word(32'h200));
    end
    while (exp_addr_q.size() > 0) begin
      e = exp_addr_q.pop_front();
      o = (obs_addr_q.size() > 0) ? obs_addr_q.pop_front() : 32'hDEAD_DEAD;
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL abort_req_addr: got %h want %h", o, e);
      end
    end
    ack_gap = 2;
  endtask

  task automatic test_flush();
    bit got;
    logic [31:0] e, o;
    step();
    bus.i_address = 32'h300;
    bus.i_rd_en   = 1'b1;
    push_line(32'h300);
    #1;
    step();
    bus.i_flush = 1'b1;
    #1;
    step();
    bus.i_flush   = 1'b0;
    bus.i_address = 32'hABC0;
    #1;
    wait_for(ModeAcks, 4, got);
    step();
    bus.i_address = 32'h300;
    #1;
    vectors++;
    if (!got || bus.o_hit !== 1'b0 || bus.o_miss !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_fill_remiss: got acks=%b hit=%b miss=%b want 1/0/1", got,
               bus.o_hit, bus.o_miss);
    end
    push_line(32'h300);
    wait_for(ModeHit, 0, got);
    step();
    bus.i_flush = 1'b1;
    #1;
    vectors++;
    if (!got || bus.o_hit !== 1'b1 || bus.o_data !== mem_word(32'h300)) begin
      miscompares++;
      $display("FAIL flush_cycle_hit: got hit=%b data=%h want 1/%h", bus.o_hit, bus.o_data,
               mem_word(32'h300));
    end
    step();
    bus.i_flush = 1'b0;
    push_line(32'h300);
    #1;
    vectors++;
    if (bus.o_miss !== 1'b1 || bus.o_hit !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_idle_miss: got miss=%b hit=%b want 1/0", bus.o_miss, bus.o_hit);
    end
    wait_for(ModeHit, 0, got);
    while (exp_addr_q.size() > 0) begin
      e = exp_addr_q.pop_front();
      o = (obs_addr_q.size() > 0) ? obs_addr_q.pop_front() : 32'hDEAD_DEAD;
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL flush_req_addr: got %h want %h", o, e);
      end
    end
  endtask

  task automatic test_reset_mid_fill();
    bit got;
    logic [31:0] e, o;
    step();
    bus.i_address = 32'h400;
    push_line(32'h400);
    #1;
    wait_for(ModeAcks, 1, got);
    step();
    rst_n = 1'b0;
    #1;
    vectors++;
    if (!got || bus.o_mem_req !== 1'b0 || bus.o_miss !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_fill: got req=%b miss=%b want 0/0", bus.o_mem_req, bus.o_miss);
    end
    exp_addr_q.delete();
    obs_addr_q.delete();
    step();
    step();
    rst_n = 1'b1;
    push_line(32'h400);
    #1;
    vectors++;
    if (bus.o_miss !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_refetch_miss: got %b want 1", bus.o_miss);
    end
    wait_for(ModeHit, 0, got);
    vectors++;
    if (!got || bus.o_data !== mem_word(32'h400)) begin
      miscompares++;
      $display("FAIL reset_refill_data: got %h want %h", bus.o_data, mem_word(32'h400));
    end
    while (exp_addr_q.size() > 0) begin
      e = exp_addr_q.pop_front();
      o = (obs_addr_q.size() > 0) ? obs_addr_q.pop_front() : 32'hDEAD_DEAD;
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL reset_req_addr: got %h want %h", o, e);
      end
    end
  endtask

`ifdef ZAP_ICACHE_STATS_EN
  task automatic test_stats();
    bit got;
    step();
    rst_n = 1'b0;
    #1;
    vectors++;
    if (hit_cnt !== 32'd0 || miss_cnt !== 32'd0) begin
      miscompares++;
      $display("FAIL stats_reset: got %0d/%0d want 0/0", hit_cnt, miss_cnt);
    end
    step();
    rst_n         = 1'b1;
    bus.i_address = 32'h600;
    bus.i_rd_en   = 1'b1;
    #1;
    wait_for(ModeHit, 0, got);
    for (int i = 1; i < 7; i++) begin
      step();
      bus.i_address = 32'h600 + 32'(4 * (i % 4));
      #1;
    end
    step();
    bus.i_rd_en = 1'b0;
    #1;
    vectors++;
    if (!got || miss_cnt !== 32'd1 || hit_cnt !== 32'd7) begin
      miscompares++;
      $display("FAIL stats_counts: got miss=%0d hit=%0d want 1/7", miss_cnt, hit_cnt);
    end
    step();
    force dut.hit_cnt_q = 32'hFFFF_FFFF;
    bus.i_address = 32'h600;
    bus.i_rd_en   = 1'b1;
    #1;
    release dut.hit_cnt_q;
    step();
    bus.i_rd_en = 1'b0;
    #1;
    vectors++;
    if (hit_cnt !== 32'd0) begin
      miscompares++;
      $display("FAIL stats_wrap: got %h want 00000000", hit_cnt);
    end
    exp_addr_q.delete();
    obs_addr_q.delete();
  endtask
`endif

  initial begin
    test_reset();
    test_cold_fill();
    test_hits_and_conflict();
    test_abort();
    test_flush();
    test_reset_mid_fill();
`ifdef ZAP_ICACHE_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
